mano_io_port: RTL and testbench
===============================

# mano_io_port

Device-side end of the basic computer's programmed-I/O interface: owns INPR/FGI and OUTR/FGO, and the IEN interrupt-enable flag driven by the CPU's INP, OUT, ION and IOF instructions. Serializes OUTR onto an 8N1 UART line and deserializes incoming UART frames into INPR. Sits beside the computer top level. The control unit pulses the instruction strobes and samples `fgi`, `fgo` and `irq` for SKI, SKO and the interrupt cycle.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal values are ≥ 4.
- clk  in  1  system clock; all state updates on its rising edge.
- clr  in  1  asynchronous, active-low reset.
- inpr  out  8  input register, to AC[7:0] on INP.
- fgi  out  1  input flag; 1 means INPR holds an unread byte.
- inp_ack  in  1  one-cycle pulse when the CPU executes INP; clears FGI.
- outr_in  in  8  AC[7:0] from the CPU.
- out_wr  in  1  one-cycle pulse when the CPU executes OUT; loads OUTR.
- fgo  out  1  output flag; 1 means the transmitter is ready.
- ion  in  1  pulse; sets IEN.
- iof  in  1  pulse; clears IEN. Also driven by the interrupt cycle.
- ien  out  1  interrupt enable.
- irq  out  1  registered: ien & (fgi | fgo).
- rxd  in  1  serial input; asynchronous, idle high.
- txd  out  1  serial output; idle high.
- rx_overrun  out  1  sticky; a frame completed while FGI=1.
- rx_frame_err  out  1  sticky; the stop bit was sampled low.

## Operation
- Reset values: inpr=0, fgi=0, outr=0, fgo=1, ien=0, irq=0, txd=1, rx_overrun=0, rx_frame_err=0. Both FSMs go to IDLE.
- The sticky error flags clear only on reset.
- **TX FSM, states IDLE→START→DATA→STOP→IDLE:**
  - out_wr with fgo=1 loads OUTR from outr_in, clears fgo and enters START.
  - out_wr with fgo=0 is ignored: OUTR is unchanged and the frame in progress is undisturbed.
  - Bits are sent LSB first, 8 data bits, 1 stop bit.
  - fgo returns to 1 on the last cycle of STOP, as the FSM returns to IDLE.
- **RX FSM, states IDLE→START→DATA→STOP→IDLE:**
  - rxd passes through a 2-flop synchronizer first.
  - A low level in IDLE enters START.
  - START re-samples at CLKS_PER_BIT/2 (integer division). If the line is high, the edge was a glitch and the FSM returns to IDLE.
  - Each data bit is sampled CLKS_PER_BIT cycles after the previous sample, LSB first.
  - **Stop sample = 1:**
    - If fgi=0: inpr ← shift register, fgi ← 1.
    - If fgi=1: rx_overrun ← 1; inpr and fgi are unchanged and the byte is discarded.
  - **Stop sample = 0:** rx_frame_err ← 1 and the byte is discarded.
  - After the stop sample the FSM always returns to IDLE.
- **Simultaneous events:**
  - inp_ack in the same cycle as a good stop sample with fgi=1: the new byte loads, fgi stays 1, no overrun.
  - ion and iof in the same cycle: iof wins, ien=0.
  - inp_ack with fgi=0 has no effect.
- The RX and TX paths are fully independent; full-duplex operation is required.

## Timing
- out_wr sampled at edge k: fgo=0 and txd=0 (start bit) from edge k+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- fgo=1 from edge k+10·CLKS_PER_BIT.
- A new out_wr may be accepted on the cycle fgo=1, so back-to-back frames have no idle gap.
- RX: fgi rises 2 + 9·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles (±1) after the falling start edge reaches rxd.
- irq lags its inputs by one cycle.
- Assertion of clr mid-frame:
  - Aborts both FSMs immediately.
  - txd goes to 1 asynchronously.
  - A partially received byte is dropped.
- Bit counters wrap only via the FSM; the baud counter width is $clog2(CLKS_PER_BIT).

## Structure
- Package mano_io_pkg:
  - enum io_state_t {IDLE, START, DATA, STOP}, shared by RX and TX.
  - Constant DATA_BITS = 8.
- Sub-module io_uart_rx holds the synchronizer, RX FSM and shift register. It outputs a one-cycle byte_valid, byte_data and frame_err.
- The FGI/overrun policy stays in mano_io_port.
- TX, OUTR/FGO and IEN/irq are coded inline in mano_io_port.

## Test plan
- Reset, then idle: txd=1, fgo=1, fgi=0, ien=0, irq=0. Pulse ion: ien=1, then irq=1 one cycle later because fgo=1.
- out_wr with outr_in=0xA5, CLKS_PER_BIT=16: the txd bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles wide; fgo=0 throughout and returns to 1 at cycle 160.
- Drive an rxd frame of 0x3C: inpr=0x3C, fgi=1 within the stated latency. Pulse inp_ack: fgi=0 next cycle.
- Send two frames, 0x11 then 0x22, with no inp_ack: inpr=0x11, rx_overrun=1. Repeat with inp_ack coincident with the second stop sample: inpr=0x22, fgi=1, no overrun.
- Drive a frame of 0x55 with the stop bit low: rx_frame_err=1, fgi stays 0, inpr unchanged. Drive a 3-cycle low glitch: no frame is started.
- Assert clr mid-TX at bit 4: txd=1 and fgo=1 immediately. A second out_wr during a busy frame is ignored, and the original byte completes.

Source files
------------

// File: rtl/mano_io_pkg.sv
// Shared types and constants for the basic computer's programmed-I/O port.
package mano_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } io_state_t;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

endpackage

// File: rtl/io_uart_rx.sv
// 8N1 UART receiver: rxd synchronizer, framing FSM and LSB-first shift register.
//
// state | meaning
// IDLE  | line high, waiting for a falling edge
// START | counting to mid start bit, re-check line low
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit, then report byte or framing error
module io_uart_rx
  import mano_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rxd,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]        BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_MAX  = BIT_IDX_W'(DATA_BITS - 1);

  io_state_t              state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   rx_s;

  assign rx_s      = sync_q[1];
  assign sync_d    = {sync_q[0], rxd};
  assign byte_data = shift_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: begin
        // Preload half a bit so START lands on the middle of the start bit.
        cnt_d = HALF_BIT;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = BIT_LAST;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = BIT_LAST;
          if (bit_q == BIT_MAX) state_d = STOP;
          else                  bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_s) byte_valid = 1'b1;
          else      frame_err  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/mano_io_port.sv
// Device side of the basic computer's programmed I/O: INPR/FGI, OUTR/FGO, IEN/irq,
// with OUTR serialized onto an 8N1 line and received frames loaded into INPR.
//
// state | meaning (TX)
// IDLE  | txd high, fgo=1, waiting for OUT
// START | driving the start bit
// DATA  | driving OUTR bits LSB first
// STOP  | driving the stop bit; fgo rises in its last cycle
module mano_io_port
  import mano_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       inp_ack,
  input  logic [7:0] outr_in,
  input  logic       out_wr,
  output logic       fgo,
  input  logic       ion,
  input  logic       iof,
  output logic       ien,
  output logic       irq,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]        BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [BIT_IDX_W-1:0] BIT_MAX  = BIT_IDX_W'(DATA_BITS - 1);

  io_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BIT_IDX_W-1:0] tx_bit_q, tx_bit_d, tx_bit_nxt;
  logic [7:0]           outr_q, outr_d;
  logic                 txd_q, txd_d;
  logic                 fgo_q, fgo_d;

  logic [7:0] inpr_q, inpr_d;
  logic       fgi_q, fgi_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       ien_q, ien_d;
  logic       irq_q, irq_d;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  io_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .clr       (clr),
    .rxd       (rxd),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

  assign tx_bit_nxt = tx_bit_q + 1'b1;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q - 1'b1;
    tx_bit_d   = tx_bit_q;
    outr_d     = outr_q;
    txd_d      = txd_q;
    fgo_d      = fgo_q;
    // fgo is only high in IDLE or the final STOP cycle, so this also chains frames.
    if (out_wr && fgo_q) begin
      outr_d     = outr_in;
      fgo_d      = 1'b0;
      tx_state_d = START;
      tx_cnt_d   = BIT_LAST;
      txd_d      = 1'b0;
    end else begin
      case (tx_state_q)
        IDLE: txd_d = 1'b1;
        START: begin
          if (tx_cnt_q == '0) begin
            tx_state_d = DATA;
            tx_cnt_d   = BIT_LAST;
            tx_bit_d   = '0;
            txd_d      = outr_q[0];
          end
        end
        DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_d = BIT_LAST;
            if (tx_bit_q == BIT_MAX) begin
              tx_state_d = STOP;
              txd_d      = 1'b1;
            end else begin
              tx_bit_d = tx_bit_nxt;
              txd_d    = outr_q[tx_bit_nxt];
            end
          end
        end
        STOP: begin
          if (tx_cnt_q == CNT_ONE) fgo_d = 1'b1;
          if (tx_cnt_q == '0) begin
            tx_state_d = IDLE;
            txd_d      = 1'b1;
          end
        end
        default: tx_state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q | rx_ferr;
    if (inp_ack) fgi_d = 1'b0;
    // An INP in the same cycle frees INPR, so the new byte is not an overrun.
    if (rx_valid) begin
      if (!fgi_q || inp_ack) begin
        inpr_d = rx_data;
        fgi_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    ien_d = ien_q;
    if (ion) ien_d = 1'b1;
    if (iof) ien_d = 1'b0;
    irq_d = ien_q & (fgi_q | fgo_q);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      outr_q     <= '0;
      txd_q      <= 1'b1;
      fgo_q      <= 1'b1;
      inpr_q     <= '0;
      fgi_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ien_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      outr_q     <= outr_d;
      txd_q      <= txd_d;
      fgo_q      <= fgo_d;
      inpr_q     <= inpr_d;
      fgi_q      <= fgi_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      ien_q      <= ien_d;
      irq_q      <= irq_d;
    end
  end

  assign inpr         = inpr_q;
  assign fgi          = fgi_q;
  assign fgo          = fgo_q;
  assign ien          = ien_q;
  assign irq          = irq_q;
  assign txd          = txd_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_mano_io_port.sv
// Directed bench for mano_io_port with CLKS_PER_BIT=16 and hand-computed expectations.
module tb_mano_io_port;

  logic       clk, clr;
  logic [7:0] inpr;
  logic       fgi, inp_ack;
  logic [7:0] outr_in;
  logic       out_wr, fgo, ion, iof, ien, irq;
  logic       rxd, txd, rx_overrun, rx_frame_err;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [9:0] tx_frame;

  mano_io_port #(.CLKS_PER_BIT(16)) dut (
    .clk         (clk),
    .clr         (clr),
    .inpr        (inpr),
    .fgi         (fgi),
    .inp_ack     (inp_ack),
    .outr_in     (outr_in),
    .out_wr      (out_wr),
    .fgo         (fgo),
    .ion         (ion),
    .iof         (iof),
    .ien         (ien),
    .irq         (irq),
    .rxd         (rxd),
    .txd         (txd),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame on rxd starting at a falling clock edge; records the
  // number of cycles from the start edge until fgi is first seen high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ack_at, output int latency);
    logic [9:0] fr;
    fr      = {stop_bit, b, 1'b0};
    latency = -1;
    for (int i = 0; i < 160; i++) begin
      rxd     = fr[i / 16];
      inp_ack = (i == ack_at);
      @(negedge clk);
      if (latency < 0 && fgi === 1'b1) latency = i + 1;
    end
    rxd     = 1'b1;
    inp_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    inp_ack = 1'b1;
    @(negedge clk);
    inp_ack = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; inp_ack = 1'b0; outr_in = 8'h00; out_wr = 1'b0;
    ion = 1'b0; iof = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    check("rst_txd", txd, 1);
    check("rst_fgo", fgo, 1);
    check("rst_fgi", fgi, 0);
    check("rst_ien", ien, 0);
    check("rst_irq", irq, 0);
    check("rst_inpr", inpr, 8'h00);
    check("rst_ovr", rx_overrun, 0);
    check("rst_ferr", rx_frame_err, 0);

    ion = 1'b1;
    @(negedge clk);
    ion = 1'b0;
    check("ion_ien", ien, 1);
    check("ion_irq_lag", irq, 0);
    @(negedge clk);
    check("ion_irq", irq, 1);

    ion = 1'b1; iof = 1'b1;
    @(negedge clk);
    ion = 1'b0; iof = 1'b0;
    check("ion_iof_ien", ien, 0);
    @(negedge clk);
    check("ion_iof_irq", irq, 0);

    // TX 0xA5; a second OUT of 0xFF mid-frame must be ignored.
    tx_frame = {1'b1, 8'hA5, 1'b0};
    outr_in = 8'hA5; out_wr = 1'b1;
    for (int n = 1; n <= 161; n++) begin
      @(negedge clk);
      if (n <= 160) begin
        check($sformatf("tx_bit_c%0d", n), txd, tx_frame[(n - 1) / 16]);
        check($sformatf("tx_fgo_c%0d", n), fgo, (n == 160) ? 1 : 0);
      end else begin
        check("tx_idle_txd", txd, 1);
        check("tx_idle_fgo", fgo, 1);
      end
      out_wr  = (n == 40);
      outr_in = (n == 40) ? 8'hFF : 8'hA5;
    end
    out_wr = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(8'h3C, 1'b1, -1, lat);
    check("rx_latency_ok", (lat >= 153 && lat <= 155) ? 1 : 0, 1);
    check("rx_3c_inpr", inpr, 8'h3C);
    check("rx_3c_fgi", fgi, 1);
    check("rx_3c_ovr", rx_overrun, 0);
    check("rx_3c_ferr", rx_frame_err, 0);
    pulse_ack();
    check("ack_fgi", fgi, 0);
    pulse_ack();
    check("ack_idle_fgi", fgi, 0);
    check("ack_idle_inpr", inpr, 8'h3C);

    send_frame(8'h11, 1'b1, -1, lat);
    check("ovr_first_inpr", inpr, 8'h11);
    check("ovr_first_fgi", fgi, 1);
    send_frame(8'h22, 1'b1, -1, lat);
    repeat (4) @(negedge clk);
    check("ovr_inpr", inpr, 8'h11);
    check("ovr_fgi", fgi, 1);
    check("ovr_flag", rx_overrun, 1);

    do_reset();
    check("rst2_ovr", rx_overrun, 0);
    check("rst2_inpr", inpr, 8'h00);
    send_frame(8'h11, 1'b1, -1, lat);
    check("coin_first_inpr", inpr, 8'h11);
    send_frame(8'h22, 1'b1, 154, lat);
    repeat (4) @(negedge clk);
    check("coin_inpr", inpr, 8'h22);
    check("coin_fgi", fgi, 1);
    check("coin_ovr", rx_overrun, 0);

    pulse_ack();
    send_frame(8'h55, 1'b0, -1, lat);
    repeat (20) @(negedge clk);
    check("ferr_flag", rx_frame_err, 1);
    check("ferr_fgi", fgi, 0);
    check("ferr_inpr", inpr, 8'h22);
    check("ferr_ovr", rx_overrun, 0);

    do_reset();
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_fgi", fgi, 0);
    check("glitch_ferr", rx_frame_err, 0);
    check("glitch_inpr", inpr, 8'h00);

    // Abort a TX frame with clr while bit 4 (data bit 3 = 0) is on the line.
    outr_in = 8'hA5; out_wr = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      out_wr = 1'b0;
    end
    check("abort_pre_txd", txd, 0);
    check("abort_pre_fgo", fgo, 0);
    #2 clr = 1'b0;
    #1;
    check("abort_txd", txd, 1);
    check("abort_fgo", fgo, 1);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_post_txd", txd, 1);
    check("abort_post_fgo", fgo, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
